seq_unsigned_divider: RTL and testbench



---
 rtl/seq_unsigned_divider_pkg.sv | 20 ++
 rtl/seq_unsigned_divider_if.sv | 31 +++
 rtl/seq_unsigned_divider_step.sv | 30 +++
 rtl/seq_unsigned_divider.sv | 108 ++++++++++
 tb/tb_seq_unsigned_divider.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_unsigned_divider_pkg.sv
// Shared types and constants for the sequential unsigned divider.
//   div_state_t : controller state (IDLE, RUN, DONE)
//   cnt_width() : width of the iteration counter for a given operand width
//   DBZ_FILL    : all-ones pattern; slice [WIDTH-1:0] for the divide-by-zero results
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The counter has to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam logic [31:0] DBZ_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_unsigned_divider_if.sv
// Request/result bundle of the sequential unsigned divider.
//   start, dividend, divisor              : requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                           : divider -> requester
// Handshake: the request is a start/done protocol, not valid/ready. A request
// is accepted on any rising edge where the divider's ena=1, start=1 and the
// divider is not busy; dividend/divisor are sampled on that edge only. start
// while busy=1 is ignored. done pulses for one enabled cycle when new results
// are written; quotient/remainder/div_by_zero then hold until the next done.
interface seq_unsigned_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_unsigned_divider_step.sv
// One restoring-division iteration (purely combinational).
//   i_p       : partial remainder, WIDTH+1 bits
//   i_a       : dividend/quotient shift register, WIDTH bits
//   i_divisor : divisor, WIDTH bits
//   o_p_next  : partial remainder after the iteration
//   o_a_next  : shift register after the iteration (new quotient bit in LSB)
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_p,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_p_next,
  output logic [WIDTH-1:0] o_a_next
);
  logic [2*WIDTH:0] w_shifted;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_neg;

  assign w_shifted = {i_p, i_a} << 1;
  assign w_p_shift = w_shifted[2*WIDTH:WIDTH];
  // P stays below the divisor, so P_shifted < 2*divisor and the MSB of the
  // WIDTH+1 bit difference is a reliable borrow (negative) indicator.
  assign w_trial   = w_p_shift - {1'b0, i_divisor};
  assign w_neg     = w_trial[WIDTH];

  assign o_p_next  = w_neg ? w_p_shift : w_trial;
  assign o_a_next  = w_shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_neg};
endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per enabled cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : global enable; when low every register holds
//   bus         : slave side of seq_unsigned_divider_if (start/operands in,
//                 busy/done/results out)
//   o_dbg_state : current controller state
// Divide by zero finishes on the accept edge with all-ones results and
// div_by_zero=1; otherwise results appear WIDTH enabled edges after accept.
module seq_unsigned_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  seq_unsigned_divider_if.slave bus,
  output div_state_t            o_dbg_state
);
  localparam int CW = cnt_width(WIDTH);

  div_state_t       r_state;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_a_next;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_p       (r_p),
    .i_a       (r_a),
    .i_divisor (r_divisor),
    .o_p_next  (w_p_next),
    .o_a_next  (w_a_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_a       <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else if (ena) begin
      // done is a single enabled-cycle pulse; it is re-raised below only on
      // completion edges.
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_divisor <= bus.divisor;
            r_p       <= '0;
            r_a       <= bus.dividend;
            r_cnt     <= CW'(WIDTH);
            if (bus.divisor != '0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_quot  <= DBZ_FILL[WIDTH-1:0];
              r_rem   <= DBZ_FILL[WIDTH-1:0];
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_p   <= w_p_next;
          r_a   <= w_a_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_quot  <= w_a_next;
            r_rem   <= w_p_next[WIDTH-1:0];
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_seq_unsigned_divider.sv
module tb_seq_unsigned_divider;
  import seq_divider_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena8 = 1'b0, ena4 = 1'b0, ena16 = 1'b0;
  always #5 clk = ~clk;

  seq_unsigned_divider_if #(.WIDTH(8))  if8  ();
  seq_unsigned_divider_if #(.WIDTH(4))  if4  ();
  seq_unsigned_divider_if #(.WIDTH(16)) if16 ();
  div_state_t st8, st4, st16;

  seq_unsigned_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .bus(if8.slave), .o_dbg_state(st8));
  seq_unsigned_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .bus(if4.slave), .o_dbg_state(st4));
  seq_unsigned_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena16), .bus(if16.slave), .o_dbg_state(st16));

  int checks = 0;
  int errors = 0;

  // scoreboard queues for the randomized run
  logic [7:0] exp_q[$];
  logic [7:0] exp_r[$];
  logic       exp_z[$];

  // ---------------- reference model ----------------
  // Plain arithmetic division; divide by zero yields all ones and the flag.
  function automatic logic [31:0] ref_q(input int unsigned a, input int unsigned b, input int w);
    return (b == 0) ? ((32'h1 << w) - 1) : (a / b);
  endfunction
  function automatic logic [31:0] ref_r(input int unsigned a, input int unsigned b, input int w);
    return (b == 0) ? ((32'h1 << w) - 1) : (a % b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request and wait for done. lat = edges after the accept edge
  // at which done was first seen; busy_n = busy samples before done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r, output logic z,
                     output int lat, output int busy_n);
    if8.dividend = a; if8.divisor = b; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    lat = 0; busy_n = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) busy_n++;
      tick();
      lat++;
    end
    checks++;
    if (!if8.done) begin
      errors++;
      $display("FAIL op8_timeout a=%0d b=%0d no done after %0d cycles", a, b, lat);
    end
    q = if8.quotient; r = if8.remainder; z = if8.div_by_zero;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] q, output logic [3:0] r, output logic z,
                     output int lat);
    if4.dividend = a; if4.divisor = b; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 40) begin tick(); lat++; end
    q = if4.quotient; r = if4.remainder; z = if4.div_by_zero;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] q, output logic [15:0] r, output logic z,
                      output int lat);
    if16.dividend = a; if16.divisor = b; if16.start = 1'b1;
    tick();
    if16.start = 1'b0;
    lat = 0;
    while (!if16.done && lat < 60) begin tick(); lat++; end
    q = if16.quotient; r = if16.remainder; z = if16.div_by_zero;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(); tick();
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if8.done); end
    checks++; if (if8.quotient !== 8'd0 || if8.remainder !== 8'd0) begin
      errors++; $display("FAIL reset_results got q=%0d r=%0d exp 0/0", if8.quotient, if8.remainder); end
    checks++; if (if8.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", if8.div_by_zero); end
    checks++; if (st8 !== IDLE || st4 !== IDLE || st16 !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d/%0d/%0d exp IDLE", st8, st4, st16); end
    rst_n = 1'b1;
    ena8 = 1'b1; ena4 = 1'b1; ena16 = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] q, r; logic z; int lat, bn;
    op8(8'd200, 8'd7, q, r, z, lat, bn);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
    checks++; if (q !== 8'd28 || r !== 8'd4 || z !== 1'b0) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d z=%b exp 28/4/0", q, r, z); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", if8.busy); end
    tick();
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", if8.done); end
    checks++; if (if8.quotient !== 8'd28) begin errors++; $display("FAIL basic_hold got %0d exp 28", if8.quotient); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic z; int lat, bn;
    op8(8'd37, 8'd0, q, r, z, lat, bn);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency got %0d exp 0", lat); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL dbz_busy got %0d exp 0", bn); end
    checks++; if (q !== 8'hFF || r !== 8'hFF || z !== 1'b1) begin
      errors++; $display("FAIL dbz_result got q=%h r=%h z=%b exp ff/ff/1", q, r, z); end
    tick();
    checks++; if (if8.done !== 1'b0 || if8.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_after got done=%b z=%b exp 0/1", if8.done, if8.div_by_zero); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r; logic z; int lat, bn, n;
    // start stays high throughout; second operands presented while running
    if8.dividend = 8'd5; if8.divisor = 8'd9; if8.start = 1'b1;
    tick();
    if8.dividend = 8'd255; if8.divisor = 8'd1;
    lat = 0;
    while (!if8.done && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 8 || if8.quotient !== 8'd0 || if8.remainder !== 8'd5) begin
      errors++; $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp 8/0/5", lat, if8.quotient, if8.remainder); end
    tick();
    if8.start = 1'b0;
    checks++; if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b done=%b exp 1/0", if8.busy, if8.done); end
    n = 0;
    while (!if8.done && n < 40) begin tick(); n++; end
    checks++; if (n !== 8 || if8.quotient !== 8'd255 || if8.remainder !== 8'd0) begin
      errors++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp 8/255/0", n, if8.quotient, if8.remainder); end
    tick();
  endtask

  task automatic test_stall();
    int done_n, first;
    if8.dividend = 8'd100; if8.divisor = 8'd3; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    checks++; if (if8.quotient !== 8'd255) begin
      errors++; $display("FAIL stall_hold_prev got %0d exp 255", if8.quotient); end
    done_n = 0; first = -1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin if8.start = 1'b1; if8.dividend = 8'd9; if8.divisor = 8'd9; end
      if (k == 4) begin if8.start = 1'b0; ena8 = 1'b0; end
      if (k == 7) ena8 = 1'b1;
      tick();
      if (if8.done) begin
        done_n++;
        if (first < 0) begin
          first = k;
          checks++; if (if8.quotient !== 8'd33 || if8.remainder !== 8'd1) begin
            errors++; $display("FAIL stall_result got q=%0d r=%0d exp 33/1", if8.quotient, if8.remainder); end
        end
      end else if (first < 0 && k == 5) begin
        checks++; if (if8.quotient !== 8'd255) begin
          errors++; $display("FAIL stall_no_intermediate got %0d exp 255", if8.quotient); end
      end
    end
    checks++; if (first !== 11) begin errors++; $display("FAIL stall_latency got %0d exp 11", first); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL stall_done_count got %0d exp 1", done_n); end
  endtask

  task automatic test_ena_hold_done();
    logic [7:0] q, r; logic z; int lat, bn;
    op8(8'd7, 8'd2, q, r, z, lat, bn);
    ena8 = 1'b0;
    tick(); tick();
    checks++; if (if8.done !== 1'b1 || if8.quotient !== 8'd3 || if8.remainder !== 8'd1) begin
      errors++; $display("FAIL ena_hold got done=%b q=%0d r=%0d exp 1/3/1", if8.done, if8.quotient, if8.remainder); end
    ena8 = 1'b1;
    tick();
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL ena_release_done got %b exp 0", if8.done); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r; logic z; int lat, bn, done_n;
    if8.dividend = 8'd250; if8.divisor = 8'd6; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got busy=%b done=%b z=%b exp 0/0/0", if8.busy, if8.done, if8.div_by_zero); end
    checks++; if (if8.quotient !== 8'd0 || if8.remainder !== 8'd0 || st8 !== IDLE) begin
      errors++; $display("FAIL rstmid_results got q=%0d r=%0d st=%0d exp 0/0/IDLE", if8.quotient, if8.remainder, st8); end
    tick(); tick();
    rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (if8.done) done_n++; end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_n); end
    op8(8'd250, 8'd6, q, r, z, lat, bn);
    checks++; if (q !== 8'd41 || r !== 8'd4 || lat !== 8) begin
      errors++; $display("FAIL rstmid_rerun got q=%0d r=%0d lat=%0d exp 41/4/8", q, r, lat); end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, q, r, eq, er; logic z, ez; int lat, bn;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      exp_q.push_back(8'(ref_q(a, b, 8)));
      exp_r.push_back(8'(ref_r(a, b, 8)));
      exp_z.push_back(b == 8'd0);
      op8(a, b, q, r, z, lat, bn);
      eq = exp_q.pop_front(); er = exp_r.pop_front(); ez = exp_z.pop_front();
      checks++; if (q !== eq || r !== er || z !== ez) begin
        errors++; $display("FAIL rand8 %0d/%0d got q=%0d r=%0d z=%b exp %0d/%0d/%b", a, b, q, r, z, eq, er, ez); end
      checks++; if (lat !== (ez ? 0 : 8)) begin
        errors++; $display("FAIL rand8_latency %0d/%0d got %0d exp %0d", a, b, lat, ez ? 0 : 8); end
    end
    tick();
  endtask

  task automatic test_widths();
    logic [3:0] q4, r4, a4, b4; logic [15:0] q16, r16, a16, b16; logic z; int lat;
    op4(4'd15, 4'd4, q4, r4, z, lat);
    checks++; if (q4 !== 4'd3 || r4 !== 4'd3 || z !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL w4_directed got q=%0d r=%0d z=%b lat=%0d exp 3/3/0/4", q4, r4, z, lat); end
    op16(16'd65535, 16'd256, q16, r16, z, lat);
    checks++; if (q16 !== 16'd255 || r16 !== 16'd255 || z !== 1'b0 || lat !== 16) begin
      errors++; $display("FAIL w16_directed got q=%0d r=%0d z=%b lat=%0d exp 255/255/0/16", q16, r16, z, lat); end
    for (int i = 0; i < 12; i++) begin
      a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      op4(a4, b4, q4, r4, z, lat);
      checks++; if (q4 !== 4'(ref_q(a4, b4, 4)) || r4 !== 4'(ref_r(a4, b4, 4)) || z !== (b4 == 4'd0)
                    || lat !== ((b4 == 4'd0) ? 0 : 4)) begin
        errors++; $display("FAIL rand4 %0d/%0d got q=%0d r=%0d z=%b lat=%0d", a4, b4, q4, r4, z, lat); end
      a16 = 16'($urandom_range(0, 65535));
      b16 = (i == 5) ? 16'd0 : 16'($urandom_range(1, 2000));
      op16(a16, b16, q16, r16, z, lat);
      checks++; if (q16 !== 16'(ref_q(a16, b16, 16)) || r16 !== 16'(ref_r(a16, b16, 16)) || z !== (b16 == 16'd0)
                    || lat !== ((b16 == 16'd0) ? 0 : 16)) begin
        errors++; $display("FAIL rand16 %0d/%0d got q=%0d r=%0d z=%b lat=%0d", a16, b16, q16, r16, z, lat); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    if8.start = 1'b0;  if8.dividend = '0;  if8.divisor = '0;
    if4.start = 1'b0;  if4.dividend = '0;  if4.divisor = '0;
    if16.start = 1'b0; if16.dividend = '0; if16.divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_stall();
    test_ena_hold_done();
    test_reset_mid();
    test_random8();
    test_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end
endmodule
